// File: rtl/uart_debug_loader.sv
// uart_debug_loader: UART program-image loader that writes instruction ROM and holds the CPU in reset while loading; UART_LOADER_CHECKSUM_EN adds a trailing checksum byte
module uart_debug_loader #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              uart_debug_pin,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [16:0] MAXW = 17'(2 ** ADDR_W);
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
  localparam logic [2:0] IDLE = 3'd0, LEN0 = 3'd1, LEN1 = 3'd2, DATA = 3'd3, DONE = 3'd5, ERR = 3'd6;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM = 3'd4, POST = CSUM;
  logic [7:0] acc;
`else
  localparam logic [2:0] POST = DONE;
`endif
  logic [2:0]    sync;
  logic [1:0]    rx_st;
  logic [CW-1:0] cnt;
  logic [2:0]    nbit;
  logic [7:0]    rx_byte;
  logic          byte_valid, frame_err;
  logic [2:0]    st;
  logic [15:0]   len, len_new;
  logic [1:0]    lane;
  logic          last;

  assign len_new = {rx_byte, len[7:0]};
  assign last = 16'(rom_addr) == len - 16'd1;

  // UART receiver: synchronize, find start edge, sample mid-bit, flag good byte or bad stop bit
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      sync       <= 3'b111;
      rx_st      <= R_IDLE;
      cnt        <= '0;
      nbit       <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[1:0], uart_debug_pin};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (rx_st)
        R_IDLE: begin
          cnt <= '0;
          if (sync[2] && !sync[1]) rx_st <= R_START;
        end
        R_START: if (cnt == HALF) begin
          cnt   <= '0;
          nbit  <= '0;
          rx_st <= sync[1] ? R_IDLE : R_DATA;
        end
        R_DATA: if (cnt == FULL) begin
          cnt     <= '0;
          rx_byte <= {sync[1], rx_byte[7:1]};
          nbit    <= nbit + 1'b1;
          if (nbit == 3'd7) rx_st <= R_STOP;
        end
        default: if (cnt == FULL) begin
          rx_st      <= R_IDLE;
          byte_valid <= sync[1];
          frame_err  <= !sync[1];
        end
      endcase
    end
  end

  // Frame parser: sync/length/data/checksum sequencing, ROM writes and CPU hold control
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      st        <= IDLE;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len       <= '0;
      lane      <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      if (rom_we && st == DATA) rom_addr <= rom_addr + 1'b1;
      if (st == DONE) begin
        cpu_hold  <= 1'b0;
        load_done <= 1'b1;
        st        <= IDLE;
      end else if (st == IDLE || st == ERR) begin
        if (byte_valid && rx_byte == SYNC) begin
          st        <= LEN0;
          cpu_hold  <= 1'b1;
          load_done <= 1'b0;
          load_err  <= 1'b0;
          rom_addr  <= '0;
          lane      <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
          acc       <= '0;
`endif
        end
      end else if (frame_err) begin
        st       <= ERR;
        load_err <= 1'b1;
      end else if (byte_valid) begin
        case (st)
          LEN0: begin
            len[7:0] <= rx_byte;
            st       <= LEN1;
          end
          LEN1: begin
            len[15:8] <= rx_byte;
            load_err  <= {1'b0, len_new} > MAXW;
            st        <= ({1'b0, len_new} > MAXW) ? ERR : (len_new == 16'd0) ? POST : DATA;
          end
          DATA: begin
            rom_wdata[{lane, 3'b000} +: 8] <= rx_byte;
            lane <= lane + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            acc  <= acc + rx_byte;
`endif
            if (lane == 2'd3) begin
              rom_we <= 1'b1;
              if (last) st <= POST;
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          CSUM: begin
            load_err <= rx_byte != acc;
            st       <= (rx_byte == acc) ? DONE : ERR;
          end
`endif
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_debug_loader.sv
// tb_uart_debug_loader: randomized frame stimulus checked against a queue-based image model
module tb_uart_debug_loader;
  localparam int CLK_FREQ = 50000000;
  localparam int BAUD = 3125000;
  localparam int ADDR_W = 12;
  localparam int BIT_NS = 1000000000 / BAUD;

  logic clk = 1'b0, sys_rst_n = 1'b0, pin = 1'b1;
  logic rom_we, cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0] rom_wdata;
  int checks = 0, errors = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] img[$];

  uart_debug_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .uart_debug_pin(pin), .rom_we(rom_we),
    .rom_addr(rom_addr), .rom_wdata(rom_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (rom_we) begin
    wa.push_back(rom_addr);
    wd.push_back(rom_wdata);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    pin = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      pin = b[i];
      #(BIT_NS);
    end
    pin = stop;
    #(BIT_NS);
    pin = 1'b1;
    #(BIT_NS / 2);
  endtask

  task automatic send_image(input int n);
    logic [7:0] s, b;
    s = 8'h00;
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
    send_byte(8'hA5);
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) begin
        b = img[i][8*j +: 8];
        s = s + b;
        send_byte(b);
      end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(s);
`endif
    #(BIT_NS);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rom_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", rom_we); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h exp 0", rom_addr); end
    checks++; if (rom_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", rom_wdata); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b exp 0", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", load_err); end
    sys_rst_n = 1'b1;
    #(BIT_NS);
  endtask

  task automatic test_spec_frame;
    logic [7:0] bytes[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL spec_hold_mid: got %b exp 1", cpu_hold); end
    foreach (bytes[i]) send_byte(bytes[i]);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'hB6);
`endif
    #(BIT_NS);
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL spec_nwr: got %0d exp 2", wa.size()); end
    checks++; if (wa[0] !== 0 || wd[0] !== 32'h00000013) begin errors++; $display("FAIL spec_w0: got %h@%h exp 00000013@0", wd[0], wa[0]); end
    checks++; if (wa[1] !== 1 || wd[1] !== 32'h00100093) begin errors++; $display("FAIL spec_w1: got %h@%h exp 00100093@1", wd[1], wa[1]); end
    checks++; if ({cpu_hold, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL spec_status: got %b exp 010", {cpu_hold, load_done, load_err}); end
  endtask

  task automatic test_ignore;
    wa.delete(); wd.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    #(BIT_NS);
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL ignore_nwr: got %0d exp 0", wa.size()); end
    checks++; if ({cpu_hold, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL ignore_status: got %b exp 010", {cpu_hold, load_done, load_err}); end
  endtask

  task automatic test_len_err;
    int n;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    #(BIT_NS);
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL len_nwr: got %0d exp 0", wa.size()); end
    checks++; if ({cpu_hold, load_done, load_err} !== 3'b101) begin errors++; $display("FAIL len_status: got %b exp 101", {cpu_hold, load_done, load_err}); end
    n = $urandom_range(1, 3);
    send_image(n);
    checks++; if (wa.size() !== n) begin errors++; $display("FAIL len_reload_nwr: got %0d exp %0d", wa.size(), n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (wa[i] !== ADDR_W'(i) || wd[i] !== img[i]) begin errors++; $display("FAIL len_reload_w%0d: got %h@%h exp %h@%h", i, wd[i], wa[i], img[i], i); end
    end
    checks++; if ({cpu_hold, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL len_reload_status: got %b exp 010", {cpu_hold, load_done, load_err}); end
  endtask

  task automatic test_random;
    int n;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 6);
      wa.delete(); wd.delete();
      send_image(n);
      checks++; if (wa.size() !== n) begin errors++; $display("FAIL rand%0d_nwr: got %0d exp %0d", k, wa.size(), n); end
      for (int i = 0; i < n; i++) begin
        checks++; if (wa[i] !== ADDR_W'(i) || wd[i] !== img[i]) begin errors++; $display("FAIL rand%0d_w%0d: got %h@%h exp %h@%h", k, i, wd[i], wa[i], img[i], i); end
      end
      checks++; if ({cpu_hold, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL rand%0d_status: got %b exp 010", k, {cpu_hold, load_done, load_err}); end
    end
  endtask

`ifdef UART_LOADER_CHECKSUM_EN
  task automatic test_bad_csum;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    #(BIT_NS);
    checks++; if (wa.size() !== 1 || wd[0] !== 32'h00000013) begin errors++; $display("FAIL csum_wr: got %0d writes data %h exp 1 writes data 00000013", wa.size(), wd[0]); end
    checks++; if ({cpu_hold, load_done, load_err} !== 3'b101) begin errors++; $display("FAIL csum_status: got %b exp 101", {cpu_hold, load_done, load_err}); end
  endtask
`endif

  task automatic test_stop_err;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22, 1'b0);
    #(BIT_NS);
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL stop_nwr: got %0d exp 0", wa.size()); end
    checks++; if ({cpu_hold, load_done, load_err} !== 3'b101) begin errors++; $display("FAIL stop_status: got %b exp 101", {cpu_hold, load_done, load_err}); end
  endtask

  task automatic test_glitch;
    logic [31:0] w;
    logic [7:0] s;
    w = $urandom;
    s = w[7:0] + w[15:8] + w[23:16] + w[31:24];
    wa.delete(); wd.delete();
    send_byte(8'hA5);
    pin = 1'b0; #100; pin = 1'b1;
    #(2 * BIT_NS);
    send_byte(8'h01); send_byte(8'h00);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(s);
`endif
    #(BIT_NS);
    checks++; if (wa.size() !== 1 || wa[0] !== 0 || wd[0] !== w) begin errors++; $display("FAIL glitch_wr: got %0d writes %h@%h exp 1 write %h@0 (sum %h)", wa.size(), wd[0], wa[0], w, s); end
    checks++; if ({cpu_hold, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL glitch_status: got %b exp 010", {cpu_hold, load_done, load_err}); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] w0, w1;
    logic [7:0] b;
    w0 = $urandom; w1 = $urandom;
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    for (int j = 0; j < 4; j++) send_byte(w0[8*j +: 8]);
    send_byte(w1[7:0]); send_byte(w1[15:8]);
    checks++; if (wa.size() !== 1 || wd[0] !== w0) begin errors++; $display("FAIL rstmid_first: got %0d writes %h exp 1 write %h", wa.size(), wd[0], w0); end
    @(negedge clk); sys_rst_n = 1'b0;
    @(negedge clk); sys_rst_n = 1'b1;
    checks++; if ({rom_we, cpu_hold, load_done, load_err} !== 4'b0000 || rom_addr !== '0 || rom_wdata !== '0) begin errors++; $display("FAIL rstmid_outputs: got we/hold/done/err %b addr %h data %h exp all 0", {rom_we, cpu_hold, load_done, load_err}, rom_addr, rom_wdata); end
    for (int j = 2; j < 4; j++) begin
      b = w1[8*j +: 8];
      send_byte(b == 8'hA5 ? 8'hA4 : b);
    end
    #(BIT_NS);
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL rstmid_nwr: got %0d exp 1", wa.size()); end
    checks++; if ({cpu_hold, load_done, load_err} !== 3'b000) begin errors++; $display("FAIL rstmid_status: got %b exp 000", {cpu_hold, load_done, load_err}); end
  endtask

  initial begin
    test_reset;
    test_spec_frame;
    test_ignore;
    test_len_err;
    test_random;
`ifdef UART_LOADER_CHECKSUM_EN
    test_bad_csum;
`endif
    test_stop_err;
    test_glitch;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
